// File: rtl/multiword_add_pkg.sv
// ---------------------------------------------------------------------------
// multiword_add_pkg
// Shared definitions for the multi-word adder controller: the FSM state
// encoding, the default slice width / word count, and a helper that sizes
// the word index register.
// ---------------------------------------------------------------------------
package multiword_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N     = 8;
    localparam int DEFAULT_WORDS = 4;

    // Word index width is $clog2(WORDS), but never narrower than one bit so
    // the single-word configuration still has a legal register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// multiword_add_ctrl_if
// Request/result handshake bundle for multiword_add_ctrl.
//   start_valid / start_ready : request handshake carrying a_in, b_in, c_in
//   sum_out                   : {final carry, N*WORDS result bits}
//   done_valid / done_ready   : result handshake
//   busy                      : controller is stepping through the words
// master = requester/consumer side, slave = the adder controller.
// ---------------------------------------------------------------------------
interface multiword_add_ctrl_if #(
    parameter int N     = multiword_add_pkg::DEFAULT_N,
    parameter int WORDS = multiword_add_pkg::DEFAULT_WORDS
);

    logic                 start_valid;
    logic                 start_ready;
    logic [N*WORDS-1:0]   a_in;
    logic [N*WORDS-1:0]   b_in;
    logic                 c_in;
    logic [N*WORDS:0]     sum_out;
    logic                 done_valid;
    logic                 done_ready;
    logic                 busy;

    modport master (
        output start_valid, a_in, b_in, c_in, done_ready,
        input  start_ready, sum_out, done_valid, busy
    );

    modport slave (
        input  start_valid, a_in, b_in, c_in, done_ready,
        output start_ready, sum_out, done_valid, busy
    );

endinterface

// File: rtl/multiword_add_ctrl_adder.sv
// ---------------------------------------------------------------------------
// N_Bit_Adder
// Combinational N-bit adder slice with carry in and carry out.
//   a, b : N-bit addends
//   cin  : carry in
//   sum  : N-bit sum
//   cout : carry out
// ---------------------------------------------------------------------------
module N_Bit_Adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_ctrl.sv
// ---------------------------------------------------------------------------
// multiword_add_ctrl
// Adds two N*WORDS-bit operands plus a carry in, one N-bit word per clock,
// through a single shared N_Bit_Adder slice.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : multiword_add_ctrl_if.slave handshake bundle
// Flow: IDLE accepts a request and latches the operands, RUN spends WORDS
// cycles feeding word[idx] through the slice, DONE presents the result until
// the consumer takes it.
// ---------------------------------------------------------------------------
module multiword_add_ctrl
    import multiword_add_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int WORDS = DEFAULT_WORDS
) (
    input logic                 clk,
    input logic                 rst,
    multiword_add_ctrl_if.slave bus
);

    localparam int            IW       = idx_width(WORDS);
    localparam int            W        = N * WORDS;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_t        state;
    state_t        next_state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  work;
    logic [W:0]    sum_reg;
    logic          accept;
    logic          last_word;
    int            sh;
    logic [N-1:0]  a_word;
    logic [N-1:0]  b_word;
    logic [N-1:0]  slice_sum;
    logic          slice_cout;
    logic [W-1:0]  merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start_ready is high exactly in IDLE, so a request is accepted whenever
    // start_valid is seen there. DONE only hands back to IDLE, which keeps a
    // new accept at least one cycle after the hand-off.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last_word  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start_valid) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    last_word  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Select the current word of each operand by shifting it down to bit 0.
    always_comb begin
        sh     = int'(idx) * N;
        a_word = N'(a_reg >> sh);
        b_word = N'(b_reg >> sh);
    end

    N_Bit_Adder #(
        .N(N)
    ) u_slice (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Partial results accumulate in 'work' so sum_out stays untouched until
    // the final word lands; that word is merged in on the way to sum_out.
    always_comb begin
        merged = (work & ~(W'({N{1'b1}}) << sh)) | (W'(slice_sum) << sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            work    <= '0;
            sum_reg <= '0;
        end else if (accept) begin
            a_reg <= bus.a_in;
            b_reg <= bus.b_in;
            carry <= bus.c_in;
            idx   <= '0;
            work  <= '0;
        end else if (state == RUN) begin
            work  <= merged;
            carry <= slice_cout;
            idx   <= idx + 1'b1;
            if (last_word) begin
                sum_reg <= {slice_cout, merged};
            end
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.busy        = (state == RUN);
    assign bus.done_valid  = (state == DONE);
    assign bus.sum_out     = sum_reg;

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning the width of the shared adder slice in bits.
REQ-002 SHALL have parameter WORDS, default 4, meaning the number of N-bit words per operand (legal range 1..64).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning the reset; synchronous, active-high.
REQ-005 SHALL have port start_valid, input, 1, meaning the request carries valid operands.
REQ-006 SHALL have port start_ready, output, 1, meaning the block can accept a request.
REQ-007 SHALL have port a_in, input, N*WORDS, meaning operand A (word 0 = bits N-1:0).
REQ-008 SHALL have port b_in, input, N*WORDS, meaning operand B.
REQ-009 SHALL have port c_in, input, 1, meaning the carry into word 0.
REQ-010 SHALL have port sum_out, output, N*WORDS+1, meaning the result {final carry, words}.
REQ-011 SHALL have port done_valid, output, 1, meaning sum_out holds a completed result.
REQ-012 SHALL have port done_ready, input, 1, meaning the consumer takes the result.
REQ-013 SHALL have port busy, output, 1, meaning the block is in RUN.

Function
REQ-014 SHALL implement a three-state machine: IDLE, RUN, DONE.
REQ-015 SHALL assert start_ready only in IDLE; a request is accepted on a cycle with start_valid && start_ready.
REQ-016 On accept, SHALL latch a_in, b_in, c_in into internal registers, clear the word index to 0, and enter RUN.
REQ-017 SHALL ignore a_in/b_in/c_in changes after accept until the next accept.
REQ-018 In RUN, each cycle SHALL apply word[idx] of A and B plus the carry register to one N-bit adder slice, store the N-bit sum into result word[idx], load the slice carry-out into the carry register, and increment idx.
REQ-019 SHALL leave RUN for DONE on the cycle it processes idx == WORDS-1; RUN SHALL last exactly WORDS cycles.
REQ-020 done_valid SHALL first be high exactly WORDS+1 rising edges after the accepting edge (the accept edge counts as edge 0).
REQ-021 In DONE, SHALL hold done_valid high and sum_out stable until done_ready is high, then return to IDLE on that edge.
REQ-022 SHALL drive sum_out[N*WORDS] with the carry out of word WORDS-1.
REQ-023 SHALL keep sum_out stable at its last value outside DONE; it SHALL be valid only while done_valid is high.
REQ-024 SHALL not accept a new request in the same cycle that DONE hands off; the earliest next accept is the cycle after the return to IDLE.
REQ-025 With WORDS == 1, SHALL spend one RUN cycle and behave as a registered N-bit add.
REQ-026 SHALL wrap arithmetic modulo 2^(N*WORDS+1), with no saturation and no overflow flag beyond the carry bit.
REQ-027 done_ready while not in DONE SHALL have no effect; start_valid outside IDLE SHALL have no effect and not be queued.

Reset
REQ-028 When rst is high at a rising edge, SHALL enter IDLE and clear the word index, the carry register, the operand registers and sum_out to 0.
REQ-029 After reset, start_ready SHALL be 1, and done_valid and busy SHALL be 0.
REQ-030 Reset asserted in RUN or DONE SHALL discard the in-flight result, with no done_valid pulse afterwards.

Structure
REQ-031 SHALL place the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default N/WORDS constants in a shared package, multiword_add_pkg.
REQ-032 SHALL instantiate exactly one N_Bit_Adder sub-module (parameter N) as the shared slice; the block SHALL contain no other adder.
REQ-033 SHALL size the word index as $clog2(WORDS), minimum 1 bit.

Verification (N=8, WORDS=4)
REQ-034 The bench SHALL drive A=0xFFFFFFFF, B=0x00000001, c_in=0 -> sum_out=0x100000000, done_valid on the 5th edge after accept, busy high for 4 cycles.
REQ-035 The bench SHALL drive A=0x12345678, B=0x11111111, c_in=1 -> sum_out=0x02345678A; hold done_ready=0 for 3 cycles -> sum_out and done_valid stay stable.
REQ-036 The bench SHALL drive start_valid with new operands held throughout RUN -> ignored, with start_ready=0 and the result unchanged.
REQ-037 The bench SHALL assert rst on the 2nd RUN cycle -> IDLE next edge, sum_out=0, and no done_valid for that request.
REQ-038 The bench SHALL issue back-to-back requests with done_ready tied high -> second accept exactly one cycle after the first DONE, and both sums correct.
REQ-039 The bench SHALL run WORDS=1 with A=0xFF, B=0xFF, c_in=1 -> sum_out=0x1FF, with done_valid 2 edges after accept.
